// File: rtl/mem_stage.sv
// Memory-access pipeline stage: pass-through for ALU ops, request/ack data-memory port for loads/stores.
// Optional ack timeout with sticky mem_err is built only when MEM_TIMEOUT_EN is defined.
module mem_stage #(
   parameter int ADDR_W = 16
`ifdef MEM_TIMEOUT_EN
   , parameter int MEM_TIMEOUT = 64
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       alu_result,
   input  logic [15:0]       store_data,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic              reg_write,
   input  logic [2:0]        rd_addr,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [15:0]       dmem_wdata,
   input  logic [15:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic [15:0]       wb_data,
   output logic [2:0]        wb_rd,
   output logic              wb_we,
   output logic              mem_err
);

   // state  | meaning
   // IDLE   | accepting; pass-through ops retire next cycle
   // ACCESS | memory request outstanding, upstream stalled
   typedef enum logic {IDLE, ACCESS} state_t;

   state_t     state, state_nxt;
   logic       fire;
   logic       is_mem;
   logic       ack;
   logic       tmo;
   logic [2:0] lat_rd;
   logic       lat_we;

   // Request follows the state register so reset removes it asynchronously.
   assign in_ready = (state == IDLE);
   assign dmem_req = (state == ACCESS);
   assign fire     = in_valid & in_ready;
   assign is_mem   = mem_rd | mem_wr;
   assign ack      = dmem_req & dmem_ack;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TC = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (fire) begin
         cnt <= '0;
      end else if (dmem_req && !dmem_ack) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Ack in the terminal cycle takes priority over the timeout.
   assign tmo = dmem_req & ~dmem_ack & (cnt == TC);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_err <= 1'b0;
      end else if (tmo) begin
         mem_err <= 1'b1;
      end
   end
`else
   assign tmo     = 1'b0;
   assign mem_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fire && is_mem) state_nxt = ACCESS;
         ACCESS:  if (ack || tmo)     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         lat_rd     <= '0;
         lat_we     <= 1'b0;
         wb_valid   <= 1'b0;
         wb_data    <= '0;
         wb_rd      <= '0;
         wb_we      <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         if (fire) begin
            if (is_mem) begin
               dmem_we    <= mem_wr;
               dmem_addr  <= alu_result[ADDR_W-1:0];
               dmem_wdata <= store_data;
               lat_rd     <= rd_addr;
               lat_we     <= reg_write;
            end else begin
               wb_valid <= 1'b1;
               wb_data  <= alu_result;
               wb_rd    <= rd_addr;
               wb_we    <= reg_write;
            end
         end else if (ack) begin
            wb_valid <= 1'b1;
            wb_rd    <= lat_rd;
            wb_we    <= dmem_we ? 1'b0 : lat_we;
            wb_data  <= dmem_we ? 16'h0000 : dmem_rdata;
         end else if (tmo) begin
            wb_valid <= 1'b1;
            wb_rd    <= lat_rd;
            wb_we    <= 1'b0;
            wb_data  <= 16'h0000;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; timeout scenarios run when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [15:0] alu_result, store_data;
   logic        mem_rd, mem_wr, reg_write;
   logic [2:0]  rd_addr;
   logic        dmem_req, dmem_we;
   logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic [15:0] wb_data;
   logic [2:0]  wb_rd;
   logic        wb_we, mem_err;

   int n_cmp = 0;
   int n_err = 0;

   mem_stage #(
      .ADDR_W(16)
`ifdef MEM_TIMEOUT_EN
      , .MEM_TIMEOUT(4)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .store_data(store_data),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_write(reg_write), .rd_addr(rd_addr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
      .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; reg_write = 1'b0;
      alu_result = 16'h0; store_data = 16'h0; rd_addr = 3'd0;
      dmem_ack = 1'b0; dmem_rdata = 16'h0;
   endtask

   task automatic present(input logic [15:0] a, input logic [15:0] sd, input logic rd_f,
                          input logic wr_f, input logic rw, input logic [2:0] rd);
      in_valid = 1'b1; alu_result = a; store_data = sd;
      mem_rd = rd_f; mem_wr = wr_f; reg_write = rw; rd_addr = rd;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_in();
      #3;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
      n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rst_dmem_req: got %b exp 0", dmem_req); end
      n_cmp++; if ({dmem_we, dmem_addr, dmem_wdata} !== 33'h0) begin n_err++; $display("FAIL rst_dmem_bus: got we=%b addr=%h wdata=%h exp 0", dmem_we, dmem_addr, dmem_wdata); end
      n_cmp++; if ({wb_valid, wb_data, wb_rd, wb_we} !== 21'h0) begin n_err++; $display("FAIL rst_wb: got v=%b d=%h rd=%0d we=%b exp 0", wb_valid, wb_data, wb_rd, wb_we); end
      n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rst_mem_err: got %b exp 0", mem_err); end
      step(); step();
      rst = 1'b1;
      step();
      n_cmp++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_release: got rdy=%b v=%b exp 1/0", in_ready, wb_valid); end
   endtask

   task automatic test_pass_through();
      present(16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 3'd3);
      step();
      clear_in();
      n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL pass_wb_valid: got %b exp 1", wb_valid); end
      n_cmp++; if (wb_data !== 16'h1234) begin n_err++; $display("FAIL pass_wb_data: got %h exp 1234", wb_data); end
      n_cmp++; if (wb_rd !== 3'd3 || wb_we !== 1'b1) begin n_err++; $display("FAIL pass_wb_rd_we: got rd=%0d we=%b exp 3/1", wb_rd, wb_we); end
      n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL pass_no_req: got %b exp 0", dmem_req); end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      n_cmp++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL stray_ack: got v=%b req=%b exp 0/0", wb_valid, dmem_req); end
      n_cmp++; if (wb_data !== 16'h1234 || wb_rd !== 3'd3) begin n_err++; $display("FAIL pass_hold: got d=%h rd=%0d exp 1234/3", wb_data, wb_rd); end
      step();
      n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL stray_ack_late: got %b exp 0", wb_valid); end
   endtask

   task automatic test_load();
      present(16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5);
      step();
      clear_in();
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (dmem_req !== 1'b1 || in_ready !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL load_wait%0d: got req=%b rdy=%b v=%b exp 1/0/0", i, dmem_req, in_ready, wb_valid); end
         n_cmp++; if (dmem_addr !== 16'h0040 || dmem_we !== 1'b0) begin n_err++; $display("FAIL load_addr%0d: got addr=%h we=%b exp 0040/0", i, dmem_addr, dmem_we); end
         if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 16'hBEEF; end
         step();
      end
      dmem_ack = 1'b0; dmem_rdata = 16'h0;
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 16'hBEEF) begin n_err++; $display("FAIL load_wb: got v=%b d=%h exp 1/beef", wb_valid, wb_data); end
      n_cmp++; if (wb_we !== 1'b1 || wb_rd !== 3'd5) begin n_err++; $display("FAIL load_wb_we_rd: got we=%b rd=%0d exp 1/5", wb_we, wb_rd); end
      n_cmp++; if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL load_done: got req=%b rdy=%b exp 0/1", dmem_req, in_ready); end
      n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL load_mem_err: got %b exp 0", mem_err); end
      step();
      n_cmp++; if (wb_valid !== 1'b0 || wb_data !== 16'hBEEF) begin n_err++; $display("FAIL load_pulse: got v=%b d=%h exp 0/beef", wb_valid, wb_data); end
   endtask

   task automatic test_store();
      // Both mem_rd and mem_wr set must still behave as a store.
      for (int k = 0; k < 2; k++) begin
         present(16'h0010, 16'hA5A5, k[0], 1'b1, 1'b1, 3'd2);
         step();
         clear_in();
         n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin n_err++; $display("FAIL store%0d_req: got req=%b we=%b exp 1/1", k, dmem_req, dmem_we); end
         n_cmp++; if (dmem_wdata !== 16'hA5A5 || dmem_addr !== 16'h0010) begin n_err++; $display("FAIL store%0d_bus: got wdata=%h addr=%h exp a5a5/0010", k, dmem_wdata, dmem_addr); end
         dmem_ack = 1'b1; dmem_rdata = 16'h7777;
         step();
         dmem_ack = 1'b0;
         n_cmp++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 16'h0) begin n_err++; $display("FAIL store%0d_wb: got v=%b we=%b d=%h exp 1/0/0000", k, wb_valid, wb_we, wb_data); end
         n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL store%0d_req_drop: got %b exp 0", k, dmem_req); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      present(16'h0020, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4);
      step();
      present(16'h0777, 16'h0, 1'b0, 1'b0, 1'b1, 3'd6);
      n_cmp++; if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_stall: got rdy=%b v=%b exp 0/0", in_ready, wb_valid); end
      step();
      n_cmp++; if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_stall2: got rdy=%b v=%b exp 0/0", in_ready, wb_valid); end
      dmem_ack = 1'b1; dmem_rdata = 16'h1111;
      step();
      dmem_ack = 1'b0;
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 16'h1111 || wb_rd !== 3'd4) begin n_err++; $display("FAIL b2b_load_wb: got v=%b d=%h rd=%0d exp 1/1111/4", wb_valid, wb_data, wb_rd); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b exp 1", in_ready); end
      step();
      clear_in();
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 16'h0777 || wb_rd !== 3'd6 || wb_we !== 1'b1) begin n_err++; $display("FAIL b2b_add_wb: got v=%b d=%h rd=%0d we=%b exp 1/0777/6/1", wb_valid, wb_data, wb_rd, wb_we); end
      step();
      n_cmp++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL b2b_no_dup: got v=%b req=%b exp 0/0", wb_valid, dmem_req); end
   endtask

   task automatic test_reset_mid_access();
      present(16'h0050, 16'h0, 1'b1, 1'b0, 1'b1, 3'd7);
      step();
      clear_in();
      step();
      n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rmid_req_before: got %b exp 1", dmem_req); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_async: got req=%b rdy=%b exp 0/1", dmem_req, in_ready); end
      n_cmp++; if ({dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_data, wb_rd, wb_we} !== 54'h0) begin n_err++; $display("FAIL rmid_outputs: got addr=%h wb_d=%h rd=%0d v=%b exp 0", dmem_addr, wb_data, wb_rd, wb_valid); end
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dmem_ack = 1'b1;
         step();
         n_cmp++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL rmid_discard%0d: got v=%b req=%b exp 0/0", i, wb_valid, dmem_req); end
      end
      dmem_ack = 1'b0;
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      present(16'h0060, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1);
      step();
      clear_in();
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (dmem_req !== 1'b1 || wb_valid !== 1'b0) begin n_err++; $display("FAIL tmo_wait%0d: got req=%b v=%b exp 1/0", i, dmem_req, wb_valid); end
         step();
      end
      n_cmp++; if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || wb_we !== 1'b0) begin n_err++; $display("FAIL tmo_expire: got req=%b v=%b we=%b exp 0/1/0", dmem_req, wb_valid, wb_we); end
      n_cmp++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b exp 1", mem_err); end
      present(16'h0001, 16'h0, 1'b0, 1'b0, 1'b1, 3'd2);
      step();
      clear_in();
      step();
      n_cmp++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b exp 1", mem_err); end
      rst = 1'b0;
      step();
      rst = 1'b1;
      n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL tmo_err_clear: got %b exp 0", mem_err); end
      present(16'h0060, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1);
      step();
      clear_in();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin dmem_ack = 1'b1; dmem_rdata = 16'h2222; end
         step();
      end
      dmem_ack = 1'b0;
      n_cmp++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_data !== 16'h2222) begin n_err++; $display("FAIL tmo_ack_wins: got v=%b we=%b d=%h exp 1/1/2222", wb_valid, wb_we, wb_data); end
      n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL tmo_ack_no_err: got %b exp 0", mem_err); end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_pass_through();
      test_load();
      test_store();
      test_back_to_back();
      test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage directly downstream of `ex2_stage`. It takes the ALU result and the store operand, performs a data-memory load or store through a request/acknowledge port, and passes non-memory results through unchanged. It presents one registered result per instruction to writeback and stalls upstream while a memory access is outstanding.

## Interface
- `ADDR_W`, 16: data-memory word-address width; `dmem_addr = alu_result[ADDR_W-1:0]`.
- `MEM_TIMEOUT`, 64: ack wait limit in cycles; used only with `MEM_TIMEOUT_EN`.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an instruction from EX2 is presented this cycle.
- `in_ready` output 1: stage can accept; combinational, high exactly in IDLE.
- `alu_result` input 16: EX2 result; this is the memory address for loads and stores.
- `store_data` input 16: value written on a store.
- `mem_rd` input 1: the instruction is a load.
- `mem_wr` input 1: the instruction is a store.
- `reg_write` input 1: the instruction writes a register.
- `rd_addr` input 3: destination register index.
- `dmem_req` output 1: memory request, held until ack.
- `dmem_we` output 1: 1 = write, 0 = read.
- `dmem_addr` output ADDR_W: word address.
- `dmem_wdata` output 16: store data.
- `dmem_rdata` input 16: load data, valid when `dmem_ack` = 1.
- `dmem_ack` input 1: completes the access; sampled only while `dmem_req` = 1.
- `wb_valid` output 1: one-cycle pulse marking a retired instruction.
- `wb_data` output 16: value to write back.
- `wb_rd` output 3: destination register.
- `wb_we` output 1: register-file write enable.
- `mem_err` output 1: sticky timeout flag.

## Operation
- States: IDLE and ACCESS.
- **IDLE**, when `in_valid` = 1 (the transfer fires):
  - If `mem_rd` = 0 and `mem_wr` = 0: pass-through. Next cycle `wb_valid` = 1, `wb_data` = `alu_result`, `wb_rd` = `rd_addr`, `wb_we` = `reg_write`. State stays IDLE.
  - If `mem_rd` = 1 or `mem_wr` = 1: latch address, store data, `rd_addr` and `reg_write`. Move to ACCESS with `dmem_req` = 1.
  - If both `mem_rd` and `mem_wr` are set, the instruction is treated as a store.
- **ACCESS**:
  - `dmem_req` = 1; `dmem_addr`, `dmem_we` and `dmem_wdata` are held stable.
  - `in_ready` = 0; upstream holds its inputs.
  - On `dmem_ack` = 1, return to IDLE. Next cycle `wb_valid` = 1 and `dmem_req` = 0.
  - Load completion: `wb_data` = captured `dmem_rdata`, `wb_we` = latched `reg_write`.
  - Store completion: `wb_we` = 0 and `wb_data` = 0.
- `wb_valid` is high for exactly one cycle per accepted instruction. Writeback never stalls.
- While `wb_valid` = 0, `wb_data`, `wb_rd` and `wb_we` hold their last values.
- A `dmem_ack` seen while `dmem_req` = 0 is ignored.

## Timing
- Reset values: state IDLE, `in_ready` 1, `dmem_req` 0, `dmem_we` 0, `dmem_addr` 0, `dmem_wdata` 0, `wb_valid` 0, `wb_data` 0, `wb_rd` 0, `wb_we` 0, `mem_err` 0.
- Pass-through latency: accepted at edge N, `wb_valid` high in cycle N+1. Back-to-back non-memory instructions sustain 1 per cycle.
- Memory latency:
  - Accepted at edge N, `dmem_req` rises in cycle N+1.
  - Ack sampled at edge M (M ≥ N+1), so `wb_valid` and `in_ready` are high in cycle M+1.
  - Minimum is 2 cycles.
- The next instruction can be accepted in the same cycle that `wb_valid` of the previous access is high.
- Reset asserted mid-ACCESS:
  - `dmem_req` drops immediately (asynchronously) and the state returns to IDLE.
  - The pending instruction is discarded with no `wb_valid`.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches `MEM_TIMEOUT`: `dmem_req` drops, state returns to IDLE, and next cycle `wb_valid` = 1 with `wb_we` = 0.
  - `mem_err` is set and stays set until reset.
  - If ack and timeout occur in the same cycle, the ack wins and `mem_err` is not set.
- `MEM_TIMEOUT_EN` not defined: ACCESS waits indefinitely, no counter is built, and `mem_err` is tied to 0.

## Test plan
- Pass-through: ADD result 0x1234, `rd_addr` 3, `reg_write` 1 → next cycle `wb_valid` 1, `wb_data` 0x1234, `wb_rd` 3, `wb_we` 1, `dmem_req` never asserted.
- Load with 3-cycle ack delay: `alu_result` 0x0040, `mem_rd` 1, memory returns 0xBEEF → `dmem_addr` 0x0040 and `dmem_we` 0 held for 3 cycles, `in_ready` 0 throughout, then `wb_data` 0xBEEF, `wb_we` 1 for one cycle.
- Store with immediate ack: `alu_result` 0x0010, `store_data` 0xA5A5 → one request cycle with `dmem_we` 1 and `dmem_wdata` 0xA5A5, then `wb_valid` 1 with `wb_we` 0.
- Back-to-back: load followed by ADD presented during ACCESS → ADD is held off until the load's `wb_valid` cycle, accepted then, and retires the next cycle with no result lost or duplicated.
- Reset mid-ACCESS: `rst` low two cycles into a load → `dmem_req` 0 immediately, no `wb_valid`, all outputs at reset values.
- With `MEM_TIMEOUT_EN` and `MEM_TIMEOUT` = 4, ack never given → request dropped after 4 cycles, `wb_valid` 1 with `wb_we` 0, `mem_err` 1 and sticky. A repeat run with ack in the fourth cycle → load completes and `mem_err` stays 0.
